// File: rtl/simple_proc_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for simple_proc_core.
package simple_proc_pkg;

    localparam int unsigned FUNC_W = 4;

    localparam logic [FUNC_W-1:0] OP_LOAD = 4'b0001;
    localparam logic [FUNC_W-1:0] OP_MOVE = 4'b0010;
    localparam logic [FUNC_W-1:0] OP_ADD  = 4'b0011;
    localparam logic [FUNC_W-1:0] OP_SUB  = 4'b0100;
    localparam logic [FUNC_W-1:0] OP_XOR  = 4'b0101;
    localparam logic [FUNC_W-1:0] OP_AND  = 4'b0110;
    localparam logic [FUNC_W-1:0] OP_OR   = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [FUNC_W-1:0] op);
        return (op >= OP_LOAD) && (op <= OP_OR);
    endfunction

    // ALU ops take the three-step T1/T2/T3 path through A and G.
    function automatic logic is_alu_op(input logic [FUNC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

endpackage

// File: rtl/simple_proc_if.sv
// Instruction handshake bus between an issuer (master) and simple_proc_core (slave).
interface simple_proc_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned REG_AW = 3
);
    import simple_proc_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [FUNC_W-1:0]   func;
    logic [REG_AW-1:0]   rx;
    logic [REG_AW-1:0]   ry;
    logic [WIDTH-1:0]    din;
    logic                done;
    logic                illegal;

    modport master (
        output instr_valid, func, rx, ry, din,
        input  instr_ready, done, illegal
    );

    modport slave (
        input  instr_valid, func, rx, ry, din,
        output instr_ready, done, illegal
    );

endinterface

// File: rtl/simple_proc_alu.sv
// Combinational ALU: modulo-2^WIDTH add/sub plus bitwise logic; carry is add carry-out or sub borrow.
module simple_proc_alu
    import simple_proc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [FUNC_W-1:0] op,
    output logic [WIDTH-1:0]  result,
    output logic              carry
);

    logic [WIDTH:0] ext;

    // The extra top bit holds carry-out for ADD and borrow for SUB.
    always_comb begin
        ext = '0;
        case (op)
            OP_ADD:  ext = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext = {1'b0, a} - {1'b0, b};
            OP_XOR:  ext = {1'b0, a ^ b};
            OP_AND:  ext = {1'b0, a & b};
            OP_OR:   ext = {1'b0, a | b};
            default: ext = '0;
        endcase
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
    end

endmodule

// File: rtl/simple_proc_core.sv
// Multi-cycle register-file processor with muxed internal bus and valid/ready instruction intake.
// Optional zero/carry flags are enabled by defining SIMPLE_PROC_FLAGS_EN.
module simple_proc_core
    import simple_proc_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              resetn,
    simple_proc_if.slave      ibus,
    output logic [WIDTH-1:0]  bus_out,
    input  logic [REG_AW-1:0] rd_idx,
    output logic [WIDTH-1:0]  rd_data
`ifdef SIMPLE_PROC_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    state_t             state;
    logic               ready_q;
    logic               done_q;
    logic               illegal_q;
    logic [FUNC_W-1:0]  func_q;
    logic [REG_AW-1:0]  rx_q;
    logic [REG_AW-1:0]  ry_q;
    logic [WIDTH-1:0]   din_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   g_q;
    logic [WIDTH-1:0]   regs [NUM_REGS];
    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   alu_result;
    logic               accept_c;
`ifdef SIMPLE_PROC_FLAGS_EN
    logic               alu_carry;
`else
    logic               alu_carry_unused;
`endif

    assign accept_c         = ibus.instr_valid & ready_q;
    assign ibus.instr_ready = ready_q;
    assign ibus.done        = done_q;
    assign ibus.illegal     = illegal_q;
    assign bus_out          = bus;
    assign rd_data          = regs[rd_idx];

    // Internal bus: one source per state, zero while idle.
    always_comb begin
        bus = '0;
        case (state)
            ST_T1: begin
                if (func_q == OP_LOAD)      bus = din_q;
                else if (func_q == OP_MOVE) bus = regs[ry_q];
                else                        bus = regs[rx_q];
            end
            ST_T2:   bus = regs[ry_q];
            ST_T3:   bus = g_q;
            default: bus = '0;
        endcase
    end

    simple_proc_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_q),
        .b      (bus),
        .op     (func_q),
        .result (alu_result),
`ifdef SIMPLE_PROC_FLAGS_EN
        .carry  (alu_carry)
`else
        .carry  (alu_carry_unused)
`endif
    );

    // Control FSM with registered handshake, done and illegal outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            func_q    <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            din_q     <= '0;
            a_q       <= '0;
            g_q       <= '0;
            regs      <= '{default: '0};
`ifdef SIMPLE_PROC_FLAGS_EN
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (is_legal_op(ibus.func)) begin
                            func_q  <= ibus.func;
                            rx_q    <= ibus.rx;
                            ry_q    <= ibus.ry;
                            din_q   <= ibus.din;
                            state   <= ST_T1;
                            ready_q <= 1'b0;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_T1: begin
                    if (is_alu_op(func_q)) begin
                        a_q   <= bus;
                        state <= ST_T2;
                    end else begin
                        regs[rx_q] <= bus;
                        done_q     <= 1'b1;
                        ready_q    <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                ST_T2: begin
                    g_q   <= alu_result;
                    state <= ST_T3;
`ifdef SIMPLE_PROC_FLAGS_EN
                    flag_z <= (alu_result == '0);
                    flag_c <= alu_carry;
`endif
                end
                ST_T3: begin
                    regs[rx_q] <= bus;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/simple_proc_core.md
Name: simple_proc_core

Overview:
Parametrised successor to the 8-register, 16-bit bus processor. Contains the register file, A and G staging registers, ALU and multi-cycle control FSM in one block. Uses a muxed internal bus instead of tri-state buffers. Accepts one instruction at a time through a valid/ready handshake and pulses done on completion; exposes a register read port for observation.

Parameters:
WIDTH, 16, datapath, register and bus width in bits
NUM_REGS, 8, number of general registers (power of 2, >=2)
REG_AW, $clog2(NUM_REGS), register index width (derived)

Ports:
clk  in  1  system clock, rising-edge
resetn  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  core can accept an instruction (high only in IDLE)
func  in  4  opcode
rx  in  REG_AW  destination / first-operand register index
ry  in  REG_AW  second-operand register index
din  in  WIDTH  immediate data for LOAD
done  out  1  one-cycle pulse: instruction retired
illegal  out  1  one-cycle pulse: unknown opcode rejected
bus_out  out  WIDTH  current internal bus value, for debug
rd_idx  in  REG_AW  debug read index
rd_data  out  WIDTH  combinational read of register rd_idx

Behaviour:
- Reset, asynchronous: all registers, A and G cleared to 0; FSM to IDLE; done=0, illegal=0, instr_ready=1.
- Opcodes: 0001 LOAD Rx<-din; 0010 MOVE Rx<-Ry; 0011 ADD Rx<-Rx+Ry; 0100 SUB Rx<-Rx-Ry; 0101 XOR; 0110 AND; 0111 OR.
- All other opcodes are illegal.
- Handshake: accept on instr_valid & instr_ready at a rising edge. func, rx, ry and din are captured into internal registers at accept; later input changes have no effect.
- instr_ready is low from the cycle after accept until the FSM returns to IDLE.
- States: IDLE, T1, T2, T3.
  - IDLE: on accept of a legal opcode go to T1. On an illegal opcode, pulse illegal next cycle, stay IDLE, write nothing.
  - T1, LOAD: bus=din, Rx written; done pulses; go to IDLE. Latency 2 clocks from accept edge.
  - T1, MOVE: bus=Ry, Rx written; done pulses; go to IDLE. Latency 2 clocks.
  - T1, ALU op: bus=Rx, A<-bus; go to T2.
  - T2: bus=Ry, G<-A op bus; go to T3.
  - T3: bus=G, Rx<-bus; done pulses; go to IDLE. ALU latency 4 clocks from accept edge.
- Back-to-back: a new instruction may be accepted in the cycle after done (IDLE). No instruction overlap.
- Arithmetic is modulo 2^WIDTH; carry and borrow are discarded (see optional feature).
- rx==ry is legal: e.g. ADD R3,R3 doubles R3.
- bus defaults to 0 in IDLE. Exactly one source drives the bus per state.
- Reset asserted mid-instruction aborts it. No partial write survives, since all state is cleared.

Optional Feature:
SIMPLE_PROC_FLAGS_EN
- Defined: adds outputs flag_z (1 bit) and flag_c (1 bit), registered at T2 of ALU ops.
  - flag_z = (result==0).
  - flag_c = carry-out for ADD; borrow (Rx<Ry unsigned) for SUB; 0 for logic ops.
  - Flags are unchanged by LOAD, MOVE and illegal opcodes; reset to 0.
- Undefined: ports absent; no flag logic.

Decomposition:
- Package simple_proc_pkg: opcode localparams (OP_LOAD..OP_OR), FSM state encoding, opcode-legality function.
- Sub-module simple_proc_alu: combinational, WIDTH-parametrised; inputs a, b and op; outputs result and carry.
- Register file, A, G and FSM stay in the top block.

Test Plan:
- Reset then rd_idx sweep -> every rd_data=0; instr_ready=1, done=0.
- LOAD R5,0x0005, then LOAD R2,0xFFFF -> done 2 clocks after each accept; rd_data[5]=0x0005, rd_data[2]=0xFFFF.
- With R5=5 and R2=0xFFFF: ADD R2,R5 -> done 4 clocks after accept; R2=0x0004; (flags build) flag_c=1, flag_z=0.
- SUB R5,R5 -> R5=0; (flags) flag_z=1, flag_c=0. MOVE R0,R2 -> R0=0x0004. instr_ready=0 throughout each execution.
- func=1001 -> illegal pulses once; no register changes; done stays 0; next LOAD is accepted normally.
- Assert resetn low during T2 of XOR R1,R3 -> all registers 0 immediately; no done pulse. Repeat with WIDTH=8, NUM_REGS=16: ADD 0xF0+0x20=0x10 in R15.
